// File: rtl/crack_pkg.sv
// Shared types and constants for the crack result controller and its
// seven-segment display decoders.
package crack_pkg;

    // Controller sequencing states, from launch request to result display.
    typedef enum logic [3:0] {
        IDLE,
        WAIT_RDY,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        RD_LEN,
        RD_BYTE,
        SEND,
        DONE
    } crs_state_t;

    // What the six digits are showing: nothing, a "no key" dash, or the key.
    typedef enum logic [1:0] {
        DISP_BLANK,
        DISP_DASH,
        DISP_KEY
    } disp_mode_t;

    // The length prefix of the recovered plaintext sits at PT address 0.
    localparam logic [7:0] LEN_ADDR = 8'd0;

    // Segment patterns are active-high here, bit 0 = a ... bit 6 = g.
    // Polarity for the board is applied in the decoder.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Hex digit glyphs 0..F; entry 15 is listed first so that
    // SEG_TABLE[n] selects the glyph for nibble n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to seven-segment decoder with blank and dash modes.
module hex7seg
    import crack_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0]  nibble_i,
    input  disp_mode_t  mode_i,
    output logic [6:0]  seg_o
);

    logic [6:0] segOn;

    // Pick the active-high glyph for the current display mode, then apply board polarity.
    always_comb begin
        segOn = SEG_BLANK;
        case (mode_i)
            DISP_DASH: segOn = SEG_DASH;
            DISP_KEY:  segOn = SEG_TABLE[nibble_i];
            default:   segOn = SEG_BLANK;
        endcase
        seg_o = ACTIVE_LOW ? ~segOn : segOn;
    end

endmodule

// File: rtl/crack_result_ctrl.sv
// Launches the key cracker, waits for its result, latches and displays the
// key, and streams the length-prefixed plaintext out of PT memory.
module crack_result_ctrl
    import crack_pkg::*;
#(
    parameter int PT_RD_LAT      = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        crk_en,
    input  logic        crk_rdy,
    input  logic [23:0] crk_key,
    input  logic        crk_key_valid,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        found,
    output logic        done,
    output logic [23:0] key_q,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    // Read data is captured when the wait counter reaches this value.
    localparam logic [1:0] LAT_LAST = 2'(PT_RD_LAT);

    crs_state_t  state_q,    state_d;
    logic        found_q,    found_d;
    logic [23:0] key_d;
    logic [7:0]  len_q,      len_d;
    logic [8:0]  idx_q,      idx_d;
    logic [1:0]  latCnt_q,   latCnt_d;
    logic [7:0]  ptAddr_q,   ptAddr_d;
    logic [7:0]  outData_q,  outData_d;
    logic        outValid_q, outValid_d;
    disp_mode_t  dispMode_q, dispMode_d;
    logic [8:0]  nextIdx;

    assign nextIdx = idx_q + 9'd1;

    // Next-state and datapath updates for the launch / wait / stream sequence.
    always_comb begin
        state_d    = state_q;
        found_d    = found_q;
        key_d      = key_q;
        len_d      = len_q;
        idx_d      = idx_q;
        latCnt_d   = latCnt_q;
        ptAddr_d   = ptAddr_q;
        outData_d  = outData_q;
        outValid_d = outValid_q;
        dispMode_d = dispMode_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_RDY;
                    found_d = 1'b0;
                end
            end
            WAIT_RDY: begin
                if (crk_rdy) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!crk_rdy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (crk_rdy) begin
                    found_d = crk_key_valid;
                    if (crk_key_valid) begin
                        key_d      = crk_key;
                        dispMode_d = DISP_KEY;
                        ptAddr_d   = LEN_ADDR;
                        latCnt_d   = 2'd0;
                        state_d    = RD_LEN;
                    end else begin
                        dispMode_d = DISP_DASH;
                        state_d    = DONE;
                    end
                end
            end
            RD_LEN: begin
                if (latCnt_q == LAT_LAST) begin
                    len_d = pt_rddata;
                    idx_d = 9'd1;
                    if (pt_rddata == 8'd0) begin
                        state_d = DONE;
                    end else begin
                        ptAddr_d = 8'd1;
                        latCnt_d = 2'd0;
                        state_d  = RD_BYTE;
                    end
                end else begin
                    latCnt_d = latCnt_q + 2'd1;
                end
            end
            RD_BYTE: begin
                if (latCnt_q == LAT_LAST) begin
                    outData_d  = pt_rddata;
                    outValid_d = 1'b1;
                    state_d    = SEND;
                end else begin
                    latCnt_d = latCnt_q + 2'd1;
                end
            end
            SEND: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    if (idx_q == {1'b0, len_q}) begin
                        state_d = DONE;
                    end else begin
                        idx_d    = nextIdx;
                        ptAddr_d = nextIdx[7:0];
                        latCnt_d = 2'd0;
                        state_d  = RD_BYTE;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    found_d = 1'b0;
                    state_d = WAIT_RDY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any run or stream in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            found_q    <= 1'b0;
            key_q      <= 24'd0;
            len_q      <= 8'd0;
            idx_q      <= 9'd0;
            latCnt_q   <= 2'd0;
            ptAddr_q   <= 8'd0;
            outData_q  <= 8'd0;
            outValid_q <= 1'b0;
            dispMode_q <= DISP_BLANK;
        end else begin
            state_q    <= state_d;
            found_q    <= found_d;
            key_q      <= key_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            latCnt_q   <= latCnt_d;
            ptAddr_q   <= ptAddr_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            dispMode_q <= dispMode_d;
        end
    end

    assign crk_en    = (state_q == LAUNCH);
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign found     = found_q;
    assign pt_addr   = ptAddr_q;
    assign out_data  = outData_q;
    assign out_valid = outValid_q;

    logic [6:0] segs [6];

    for (genvar g = 0; g < 6; g++) begin : g_hex
        hex7seg #(
            .ACTIVE_LOW(SEG_ACTIVE_LOW != 0)
        ) u_hex (
            .nibble_i(key_q[4*g +: 4]),
            .mode_i  (dispMode_q),
            .seg_o   (segs[g])
        );
    end

    assign hex0 = segs[0];
    assign hex1 = segs[1];
    assign hex2 = segs[2];
    assign hex3 = segs[3];
    assign hex4 = segs[4];
    assign hex5 = segs[5];

endmodule

// File: tb/tb_crack_result_ctrl.sv
// Directed self-checking bench for crack_result_ctrl with a PT memory model
// and a hand-driven cracker handshake.
module tb_crack_result_ctrl;

    localparam int PT_RD_LAT = 1;

    // Active-low glyphs used by the checks.
    localparam logic [6:0] H_BLANK = 7'h7F;
    localparam logic [6:0] H_DASH  = 7'h3F;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        crk_en;
    logic        crk_rdy;
    logic [23:0] crk_key;
    logic        crk_key_valid;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_rddata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        found;
    logic        done;
    logic [23:0] key_q;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    logic [6:0]  hexV [6];
    logic [7:0]  ptMem [256];
    logic [7:0]  rd1, rd2;
    logic [7:0]  rxQ [$];
    int          crkEnCnt;
    int          passCnt;
    int          totalCnt;

    crack_result_ctrl #(
        .PT_RD_LAT     (PT_RD_LAT),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .crk_en       (crk_en),
        .crk_rdy      (crk_rdy),
        .crk_key      (crk_key),
        .crk_key_valid(crk_key_valid),
        .pt_addr      (pt_addr),
        .pt_rddata    (pt_rddata),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .found        (found),
        .done         (done),
        .key_q        (key_q),
        .hex0         (hex0),
        .hex1         (hex1),
        .hex2         (hex2),
        .hex3         (hex3),
        .hex4         (hex4),
        .hex5         (hex5)
    );

    assign hexV[0] = hex0;
    assign hexV[1] = hex1;
    assign hexV[2] = hex2;
    assign hexV[3] = hex3;
    assign hexV[4] = hex4;
    assign hexV[5] = hex5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PT memory with registered read, one or two stages deep.
    always @(posedge clk) begin
        rd1 <= ptMem[pt_addr];
        rd2 <= rd1;
    end
    assign pt_rddata = (PT_RD_LAT == 1) ? rd1 : rd2;

    // Record accepted bytes and launch pulses between edges.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) rxQ.push_back(out_data);
        if (!rst && crk_en) crkEnCnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait for the launch pulse, act busy for a while (with a stray key_valid
    // pulse), then return ready with the given result. Ends right after rdy rises.
    task automatic runCracker(input logic [23:0] key, input logic kv, input int busyCyc,
                              input bit startDuringBusy, output bit launched);
        launched = 1'b0;
        for (int i = 0; i < 50 && !launched; i++) begin
            tick();
            if (crk_en) launched = 1'b1;
        end
        if (launched) begin
            tick();
            crk_rdy       = 1'b0;
            crk_key_valid = 1'b0;
            tick();
            crk_key       = 24'hBADBAD;
            crk_key_valid = 1'b1;
            if (startDuringBusy) start = 1'b1;
            tick();
            crk_key_valid = 1'b0;
            start         = 1'b0;
            for (int i = 0; i < busyCyc; i++) tick();
            crk_key       = key;
            crk_key_valid = kv;
            crk_rdy       = 1'b1;
        end
    endtask

    task automatic waitDone(input int maxCyc, output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        while (!ok && cycles < maxCyc) begin
            tick();
            cycles++;
            if (done) ok = 1'b1;
        end
    endtask

    task automatic waitValid(input int maxCyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxCyc && !ok; i++) begin
            tick();
            if (out_valid) ok = 1'b1;
        end
    endtask

    task automatic applyStimulus(input int len, input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2);
        ptMem[0] = 8'(len);
        ptMem[1] = b0;
        ptMem[2] = b1;
        ptMem[3] = b2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        totalCnt++; if (crk_en !== 1'b0) $display("[TB] FAIL reset_crk_en got=%b exp=0", crk_en); else passCnt++;
        totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", busy); else passCnt++;
        totalCnt++; if (done !== 1'b0) $display("[TB] FAIL reset_done got=%b exp=0", done); else passCnt++;
        totalCnt++; if (found !== 1'b0) $display("[TB] FAIL reset_found got=%b exp=0", found); else passCnt++;
        totalCnt++; if (key_q !== 24'd0) $display("[TB] FAIL reset_key got=%h exp=000000", key_q); else passCnt++;
        totalCnt++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); else passCnt++;
        totalCnt++; if (out_data !== 8'd0) $display("[TB] FAIL reset_out_data got=%h exp=00", out_data); else passCnt++;
        totalCnt++; if (pt_addr !== 8'd0) $display("[TB] FAIL reset_pt_addr got=%h exp=00", pt_addr); else passCnt++;
        for (int i = 0; i < 6; i++) begin
            totalCnt++; if (hexV[i] !== H_BLANK) $display("[TB] FAIL reset_hex%0d got=%h exp=%h", i, hexV[i], H_BLANK); else passCnt++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_found();
        bit ok; int cyc; int rx0; int en0;
        logic [6:0] expHex [6];
        expHex = '{7'h79, 7'h0E, 7'h30, 7'h08, 7'h40, 7'h40};
        $display("[TB] found run, len=3");
        applyStimulus(3, 8'h61, 8'h62, 8'h63);
        out_ready = 1'b1;
        rx0 = rxQ.size();
        en0 = crkEnCnt;
        pulseStart();
        totalCnt++; if (busy !== 1'b1) $display("[TB] FAIL found_busy got=%b exp=1", busy); else passCnt++;
        runCracker(24'h00A3F1, 1'b1, 4, 1'b0, ok);
        totalCnt++; if (ok !== 1'b1) $display("[TB] FAIL found_launch got=%b exp=1", ok); else passCnt++;
        waitDone(100, ok, cyc);
        totalCnt++; if (ok !== 1'b1) $display("[TB] FAIL found_done_timeout got=%b exp=1", ok); else passCnt++;
        totalCnt++; if (rxQ.size() - rx0 !== 3) $display("[TB] FAIL found_nbytes got=%0d exp=3", rxQ.size() - rx0); else passCnt++;
        if (rxQ.size() - rx0 == 3) begin
            totalCnt++; if (rxQ[rx0] !== 8'h61) $display("[TB] FAIL found_byte0 got=%h exp=61", rxQ[rx0]); else passCnt++;
            totalCnt++; if (rxQ[rx0+1] !== 8'h62) $display("[TB] FAIL found_byte1 got=%h exp=62", rxQ[rx0+1]); else passCnt++;
            totalCnt++; if (rxQ[rx0+2] !== 8'h63) $display("[TB] FAIL found_byte2 got=%h exp=63", rxQ[rx0+2]); else passCnt++;
        end
        totalCnt++; if (found !== 1'b1) $display("[TB] FAIL found_flag got=%b exp=1", found); else passCnt++;
        totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL found_busy_end got=%b exp=0", busy); else passCnt++;
        totalCnt++; if (key_q !== 24'h00A3F1) $display("[TB] FAIL found_key got=%h exp=00a3f1", key_q); else passCnt++;
        totalCnt++; if (crkEnCnt - en0 !== 1) $display("[TB] FAIL found_en_count got=%0d exp=1", crkEnCnt - en0); else passCnt++;
        for (int i = 0; i < 6; i++) begin
            totalCnt++; if (hexV[i] !== expHex[i]) $display("[TB] FAIL found_hex%0d got=%h exp=%h", i, hexV[i], expHex[i]); else passCnt++;
        end
    endtask

    task automatic test_not_found();
        bit ok; int cyc; int rx0;
        $display("[TB] not-found run");
        applyStimulus(3, 8'h41, 8'h42, 8'h43);
        out_ready = 1'b1;
        rx0 = rxQ.size();
        pulseStart();
        totalCnt++; if (done !== 1'b0) $display("[TB] FAIL nf_done_cleared got=%b exp=0", done); else passCnt++;
        totalCnt++; if (found !== 1'b0) $display("[TB] FAIL nf_found_cleared got=%b exp=0", found); else passCnt++;
        runCracker(24'h777777, 1'b0, 3, 1'b0, ok);
        totalCnt++; if (ok !== 1'b1) $display("[TB] FAIL nf_launch got=%b exp=1", ok); else passCnt++;
        waitDone(100, ok, cyc);
        totalCnt++; if (ok !== 1'b1) $display("[TB] FAIL nf_done_timeout got=%b exp=1", ok); else passCnt++;
        for (int i = 0; i < 5; i++) tick();
        totalCnt++; if (rxQ.size() - rx0 !== 0) $display("[TB] FAIL nf_nbytes got=%0d exp=0", rxQ.size() - rx0); else passCnt++;
        totalCnt++; if (found !== 1'b0) $display("[TB] FAIL nf_found got=%b exp=0", found); else passCnt++;
        totalCnt++; if (done !== 1'b1) $display("[TB] FAIL nf_done got=%b exp=1", done); else passCnt++;
        totalCnt++; if (key_q !== 24'h00A3F1) $display("[TB] FAIL nf_key_kept got=%h exp=00a3f1", key_q); else passCnt++;
        for (int i = 0; i < 6; i++) begin
            totalCnt++; if (hexV[i] !== H_DASH) $display("[TB] FAIL nf_hex%0d got=%h exp=%h", i, hexV[i], H_DASH); else passCnt++;
        end
    endtask

    task automatic test_backpressure();
        bit ok; int cyc; int rx0; int holdBad;
        $display("[TB] backpressure run, len=2");
        applyStimulus(2, 8'h11, 8'h22, 8'h33);
        out_ready = 1'b0;
        rx0 = rxQ.size();
        pulseStart();
        runCracker(24'h0BEEF0, 1'b1, 2, 1'b0, ok);
        waitValid(50, ok);
        totalCnt++; if (ok !== 1'b1) $display("[TB] FAIL bp_valid_timeout got=%b exp=1", ok); else passCnt++;
        holdBad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_data !== 8'h11) holdBad++;
            tick();
        end
        totalCnt++; if (holdBad !== 0) $display("[TB] FAIL bp_hold bad_cycles=%0d exp=0", holdBad); else passCnt++;
        out_ready = 1'b1;
        waitDone(100, ok, cyc);
        totalCnt++; if (ok !== 1'b1) $display("[TB] FAIL bp_done_timeout got=%b exp=1", ok); else passCnt++;
        totalCnt++; if (rxQ.size() - rx0 !== 2) $display("[TB] FAIL bp_nbytes got=%0d exp=2", rxQ.size() - rx0); else passCnt++;
        if (rxQ.size() - rx0 == 2) begin
            totalCnt++; if (rxQ[rx0] !== 8'h11) $display("[TB] FAIL bp_byte0 got=%h exp=11", rxQ[rx0]); else passCnt++;
            totalCnt++; if (rxQ[rx0+1] !== 8'h22) $display("[TB] FAIL bp_byte1 got=%h exp=22", rxQ[rx0+1]); else passCnt++;
        end
    endtask

    task automatic test_len_zero();
        bit ok; int cyc; int rx0;
        $display("[TB] found key with len=0");
        applyStimulus(0, 8'h99, 8'h98, 8'h97);
        out_ready = 1'b1;
        rx0 = rxQ.size();
        pulseStart();
        runCracker(24'h000005, 1'b1, 2, 1'b0, ok);
        waitDone(20, ok, cyc);
        totalCnt++; if (ok !== 1'b1) $display("[TB] FAIL l0_done_timeout got=%b exp=1", ok); else passCnt++;
        totalCnt++; if (cyc > PT_RD_LAT + 2) $display("[TB] FAIL l0_latency got=%0d exp<=%0d", cyc, PT_RD_LAT + 2); else passCnt++;
        totalCnt++; if (rxQ.size() - rx0 !== 0) $display("[TB] FAIL l0_nbytes got=%0d exp=0", rxQ.size() - rx0); else passCnt++;
        totalCnt++; if (found !== 1'b1) $display("[TB] FAIL l0_found got=%b exp=1", found); else passCnt++;
        totalCnt++; if (hex0 !== 7'h12) $display("[TB] FAIL l0_hex0 got=%h exp=12", hex0); else passCnt++;
    endtask

    task automatic test_start_ignored();
        bit ok; int cyc; int rx0; int en0; int earlyEn;
        $display("[TB] start while cracker busy / mid-run");
        applyStimulus(1, 8'h5A, 8'h00, 8'h00);
        out_ready = 1'b0;
        crk_rdy   = 1'b0;
        rx0 = rxQ.size();
        en0 = crkEnCnt;
        pulseStart();
        earlyEn = 0;
        for (int i = 0; i < 6; i++) begin
            if (crk_en !== 1'b0) earlyEn++;
            tick();
        end
        totalCnt++; if (earlyEn !== 0) $display("[TB] FAIL si_early_en got=%0d exp=0", earlyEn); else passCnt++;
        totalCnt++; if (busy !== 1'b1) $display("[TB] FAIL si_busy_wait got=%b exp=1", busy); else passCnt++;
        crk_rdy = 1'b1;
        runCracker(24'h654321, 1'b1, 3, 1'b1, ok);
        totalCnt++; if (ok !== 1'b1) $display("[TB] FAIL si_launch got=%b exp=1", ok); else passCnt++;
        waitValid(50, ok);
        totalCnt++; if (ok !== 1'b1) $display("[TB] FAIL si_valid_timeout got=%b exp=1", ok); else passCnt++;
        pulseStart();
        tick();
        out_ready = 1'b1;
        waitDone(50, ok, cyc);
        totalCnt++; if (ok !== 1'b1) $display("[TB] FAIL si_done_timeout got=%b exp=1", ok); else passCnt++;
        for (int i = 0; i < 4; i++) tick();
        totalCnt++; if (crkEnCnt - en0 !== 1) $display("[TB] FAIL si_en_count got=%0d exp=1", crkEnCnt - en0); else passCnt++;
        totalCnt++; if (rxQ.size() - rx0 !== 1) $display("[TB] FAIL si_nbytes got=%0d exp=1", rxQ.size() - rx0); else passCnt++;
        totalCnt++; if (done !== 1'b1) $display("[TB] FAIL si_done_held got=%b exp=1", done); else passCnt++;
    endtask

    task automatic test_reset_mid_send();
        bit ok; int cyc; int rx0;
        $display("[TB] reset during SEND, then a clean run");
        applyStimulus(3, 8'h61, 8'h62, 8'h63);
        out_ready = 1'b0;
        pulseStart();
        runCracker(24'h00A3F1, 1'b1, 2, 1'b0, ok);
        waitValid(50, ok);
        totalCnt++; if (ok !== 1'b1) $display("[TB] FAIL rs_valid_timeout got=%b exp=1", ok); else passCnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        totalCnt++; if (out_valid !== 1'b0) $display("[TB] FAIL rs_out_valid got=%b exp=0", out_valid); else passCnt++;
        totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL rs_busy got=%b exp=0", busy); else passCnt++;
        totalCnt++; if (done !== 1'b0) $display("[TB] FAIL rs_done got=%b exp=0", done); else passCnt++;
        for (int i = 0; i < 6; i++) begin
            totalCnt++; if (hexV[i] !== H_BLANK) $display("[TB] FAIL rs_hex%0d got=%h exp=%h", i, hexV[i], H_BLANK); else passCnt++;
        end
        out_ready = 1'b1;
        crk_rdy   = 1'b1;
        tick();
        rx0 = rxQ.size();
        pulseStart();
        runCracker(24'h123456, 1'b1, 3, 1'b0, ok);
        waitDone(100, ok, cyc);
        totalCnt++; if (ok !== 1'b1) $display("[TB] FAIL rs_rerun_done got=%b exp=1", ok); else passCnt++;
        totalCnt++; if (rxQ.size() - rx0 !== 3) $display("[TB] FAIL rs_rerun_nbytes got=%0d exp=3", rxQ.size() - rx0); else passCnt++;
        if (rxQ.size() - rx0 == 3) begin
            totalCnt++; if (rxQ[rx0+2] !== 8'h63) $display("[TB] FAIL rs_rerun_byte2 got=%h exp=63", rxQ[rx0+2]); else passCnt++;
        end
        totalCnt++; if (key_q !== 24'h123456) $display("[TB] FAIL rs_rerun_key got=%h exp=123456", key_q); else passCnt++;
        totalCnt++; if (hex0 !== 7'h02) $display("[TB] FAIL rs_rerun_hex0 got=%h exp=02", hex0); else passCnt++;
        totalCnt++; if (hex5 !== 7'h79) $display("[TB] FAIL rs_rerun_hex5 got=%h exp=79", hex5); else passCnt++;
    endtask

    initial begin
        passCnt       = 0;
        totalCnt      = 0;
        crkEnCnt      = 0;
        rst           = 1'b1;
        start         = 1'b0;
        crk_rdy       = 1'b1;
        crk_key       = 24'd0;
        crk_key_valid = 1'b0;
        out_ready     = 1'b0;
        for (int i = 0; i < 256; i++) ptMem[i] = 8'(i ^ 8'hA5);

        test_reset();
        test_found();
        test_not_found();
        test_backpressure();
        test_len_zero();
        test_start_ignored();
        test_reset_mid_send();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
